// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, false-start rejection,
// runtime parity / stop-bit config and a valid/ready holding register.
module uart_rx_os #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic                  rx_serial,
  input  logic                  cfg_parity_en,
  input  logic                  cfg_parity_odd,
  input  logic                  cfg_two_stop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] NBITS = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BRK
  } state_t;

  state_t                state_q;
  logic [1:0]            sync_q;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         bit_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  pen_q;
  logic                  podd_q;
  logic                  two_q;
  logic                  par_bad_q;
  logic                  stop_bad_q;
  logic                  valid_q;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  ovr_q;
  logic                  busy_q;

  logic rx_s;
  logic smp;
  logic done;
  logic stop_bad;
  logic good;
  logic load;

  assign rx_s = sync_q[1];
  assign smp  = sample_tick && (cnt_q == LAST);

  // last stop sample of the frame is taken this cycle
  assign done = smp && ((state_q == STOP1 && !two_q) ||
                        state_q == STOP2);
  assign stop_bad = !rx_s || (state_q == STOP2 && stop_bad_q);
  assign good = done && !stop_bad && !par_bad_q;
  assign load = good && (!valid_q || data_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      pen_q      <= 1'b0;
      podd_q     <= 1'b0;
      two_q      <= 1'b0;
      par_bad_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_serial};
      perr_q <= done && !stop_bad && par_bad_q;
      ferr_q <= done && stop_bad;
      ovr_q  <= good && !load;

      if (load) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (data_ready) begin
        valid_q <= 1'b0;
      end

      if (sample_tick) cnt_q <= cnt_q + CW'(1);

      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (sample_tick && !rx_s) begin
            state_q    <= START;
            busy_q     <= 1'b1;
            pen_q      <= cfg_parity_en;
            podd_q     <= cfg_parity_odd;
            two_q      <= cfg_two_stop;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            bit_q      <= '0;
          end
        end
        START: begin
          if (sample_tick && cnt_q == HALF) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (smp) begin
            shift_q <= {rx_s, shift_q[DATA_WIDTH-1:1]};
            bit_q   <= bit_q + BW'(1);
            if (bit_q == NBITS)
              state_q <= pen_q ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (smp) begin
            par_bad_q <= rx_s != ((^shift_q) ^ podd_q);
            state_q   <= STOP1;
          end
        end
        STOP1: begin
          if (smp) begin
            if (two_q) begin
              stop_bad_q <= !rx_s;
              state_q    <= STOP2;
            end else begin
              state_q <= stop_bad ? BRK : IDLE;
              busy_q  <= stop_bad;
            end
          end
        end
        STOP2: begin
          if (smp) begin
            state_q <= stop_bad ? BRK : IDLE;
            busy_q  <= stop_bad;
          end
        end
        BRK: begin
          cnt_q <= '0;
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frame table plus glitch, break,
// overrun and mid-frame reset sequences.
module tb_uart_rx_os;

  localparam int DW  = 8;
  localparam int OS  = 16;
  localparam int BIT = 2 * OS;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       two;
    logic       s1;
    logic       s2;
    logic       ev;
    int         ep;
    int         ef;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          div = 1'b0;
  logic          sample_tick;
  logic          rx = 1'b1;
  logic          pen = 1'b0;
  logic          podd = 1'b0;
  logic          two = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic          perr;
  logic          ferr;
  logic          ovr;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int n_ovr = 0;

  vec_t v[12];

  uart_rx_os #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sample_tick    (sample_tick),
    .rx_serial      (rx),
    .cfg_parity_en  (pen),
    .cfg_parity_odd (podd),
    .cfg_two_stop   (two),
    .data_out       (dout),
    .data_valid     (dvalid),
    .data_ready     (ready),
    .parity_err     (perr),
    .frame_err      (ferr),
    .overrun_err    (ovr),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) div <= ~div;
  assign sample_tick = div;

  always @(negedge clk) begin
    if (perr) n_perr <= n_perr + 1;
    if (ferr) n_ferr <= n_ferr + 1;
    if (ovr)  n_ovr  <= n_ovr + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic p_en,
                      input logic p_odd, input logic pbit,
                      input logic t_stop, input logic s1,
                      input logic s2);
    pen  = p_en;
    podd = p_odd;
    two  = t_stop;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (p_en) send_bit(pbit);
    send_bit(s1);
    if (t_stop) send_bit(s2);
    rx = 1'b1;
  endtask

  task automatic consume(input string nm);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    chk(nm, int'(dvalid), 0);
  endtask

  initial begin
    int p0, f0, o0, nb;
    //        data   pen podd pb two s1 s2  ev  ep ef
    v[0]  = '{8'hA5, Y, N, N, N, Y, Y, Y, 0, 0};
    v[1]  = '{8'h3C, Y, Y, N, N, Y, Y, N, 1, 0};
    v[2]  = '{8'h3C, Y, Y, Y, N, Y, Y, Y, 0, 0};
    v[3]  = '{8'h00, N, N, N, N, Y, Y, Y, 0, 0};
    v[4]  = '{8'hFF, N, N, N, Y, Y, Y, Y, 0, 0};
    v[5]  = '{8'h81, Y, N, N, Y, Y, Y, Y, 0, 0};
    v[6]  = '{8'h7F, Y, Y, N, N, Y, Y, Y, 0, 0};
    v[7]  = '{8'h7F, Y, N, N, N, Y, Y, N, 1, 0};
    v[8]  = '{8'h42, N, N, N, N, N, Y, N, 0, 1};
    v[9]  = '{8'h42, N, N, N, Y, N, Y, N, 0, 1};
    v[10] = '{8'h3C, Y, Y, N, N, N, Y, N, 0, 1};
    v[11] = '{8'h42, N, N, N, Y, Y, N, N, 0, 1};

    repeat (3) @(negedge clk);
    chk("rst_data", int'(dout), 0);
    chk("rst_valid", int'(dvalid), 0);
    chk("rst_perr", int'(perr), 0);
    chk("rst_ferr", int'(ferr), 0);
    chk("rst_ovr", int'(ovr), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      p0 = n_perr;
      f0 = n_ferr;
      send(v[i].d, v[i].pen, v[i].podd, v[i].pbit,
           v[i].two, v[i].s1, v[i].s2);
      repeat (8) @(negedge clk);
      chk($sformatf("v%0d_valid", i), int'(dvalid), int'(v[i].ev));
      if (v[i].ev)
        chk($sformatf("v%0d_data", i), int'(dout), int'(v[i].d));
      chk($sformatf("v%0d_perr", i), n_perr - p0, v[i].ep);
      chk($sformatf("v%0d_ferr", i), n_ferr - f0, v[i].ef);
      chk($sformatf("v%0d_busy", i), int'(busy), 0);
      if (v[i].ev) consume($sformatf("v%0d_consume", i));
    end

    // short low glitch on an idle line
    p0 = n_perr;
    f0 = n_ferr;
    nb = 0;
    for (int i = 0; i < 3 * BIT; i++) begin
      rx = (i < 8) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy) nb++;
    end
    chk("glitch_busy_seen", int'(nb > 0), 1);
    chk("glitch_busy_short", int'(nb < BIT), 1);
    chk("glitch_flags", (n_perr - p0) + (n_ferr - f0), 0);
    chk("glitch_valid", int'(dvalid), 0);
    chk("glitch_busy_end", int'(busy), 0);

    // 20-bit break
    pen = 1'b0;
    two = 1'b0;
    f0 = n_ferr;
    rx = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    chk("brk_busy", int'(busy), 1);
    chk("brk_ferr", n_ferr - f0, 1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("brk_idle", int'(busy), 0);
    send(8'h55, N, N, N, N, Y, Y);
    repeat (8) @(negedge clk);
    chk("brk_next_valid", int'(dvalid), 1);
    chk("brk_next_data", int'(dout), 'h55);
    chk("brk_ferr_once", n_ferr - f0, 1);
    consume("brk_next_consume");

    // overrun with 8N2 back-to-back frames
    o0 = n_ovr;
    send(8'h11, N, N, N, Y, Y, Y);
    send(8'h22, N, N, N, Y, Y, Y);
    repeat (8) @(negedge clk);
    chk("ovr_valid", int'(dvalid), 1);
    chk("ovr_data_held", int'(dout), 'h11);
    chk("ovr_pulse", n_ovr - o0, 1);
    consume("ovr_consume");
    repeat (BIT) @(negedge clk);
    chk("ovr_no_new_word", int'(dvalid), 0);
    chk("ovr_pulse_once", n_ovr - o0, 1);

    // reset during data bit 3
    send(8'hC3, N, N, N, N, Y, Y);
    repeat (8) @(negedge clk);
    chk("pre_rst_valid", int'(dvalid), 1);
    chk("pre_rst_data", int'(dout), 'hC3);
    p0 = n_perr;
    f0 = n_ferr;
    o0 = n_ovr;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(dvalid), 0);
    chk("mid_rst_data", int'(dout), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_errs", int'({perr, ferr, ovr}), 0);
    @(negedge clk);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send(8'h5A, N, N, N, N, Y, Y);
    repeat (8) @(negedge clk);
    chk("post_rst_valid", int'(dvalid), 1);
    chk("post_rst_data", int'(dout), 'h5A);
    chk("post_rst_flags",
        (n_perr - p0) + (n_ferr - f0) + (n_ovr - o0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
